// File: rtl/whack_engine.sv
// whack_engine: Whac-a-Mole game core. Decodes PS/2 scan codes into hole
// whacks and START, runs the mole lifetimes on a divided game tick, spawns
// moles from an LFSR, and keeps score, lives and the game phase.
module whack_engine #(
  parameter int N_HOLES    = 9,
  parameter int MAX_ACTIVE = 1,
  parameter int TICK_DIV   = 12_500_000,
  parameter int UP_TICKS   = 8,
  parameter int SCORE_W    = 8,
  parameter int LIVES_INIT = 3,
  parameter int PENALTY    = 0
) (
  input  logic               clk,
  input  logic               reset_m,
  input  logic [7:0]         iKeyboard_data,
  input  logic               iKeyboard_data_en,
  output logic [N_HOLES-1:0] oMoles,
  output logic               oChanged,
  output logic [SCORE_W-1:0] oScore,
  output logic [3:0]         oLives,
  output logic [1:0]         oState,
  output logic               oHit,
  output logic               oMiss
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  localparam int                 CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         NH4       = 4'(N_HOLES);
  localparam logic [3:0]         MA4       = 4'(MAX_ACTIVE);
  localparam logic [3:0]         LIVES4    = 4'(LIVES_INIT);
  localparam logic [7:0]         UP8       = 8'(UP_TICKS);

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             brk;
  logic [15:0]      lfsr;
  logic [7:0]       life [N_HOLES];

  logic               is_start, is_hole, hole_ok;
  logic [3:0]         key_hole;
  logic               play, tick, empty_whack;
  logic [N_HOLES-1:0] key_mask, hit_mask, expire_mask, remain, spawn_mask;
  logic [3:0]         cand;
  logic [4:0]         loss;
  logic [3:0]         lives_after;
  logic [SCORE_W-1:0] score_inc;

  state_t             state_next;
  logic [N_HOLES-1:0] moles_next;
  logic [SCORE_W-1:0] score_next;
  logic [3:0]         lives_next;
  logic               hit_next, miss_next;

  function automatic logic [3:0] popcount(input logic [N_HOLES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N_HOLES; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  assign oState = state;

  // Turn a valid scan byte into START or a hole index; the byte after a break prefix is swallowed
  always_comb begin
    is_start = 1'b0;
    is_hole  = 1'b0;
    key_hole = 4'd0;
    if (iKeyboard_data_en && !brk) begin
      case (iKeyboard_data)
        8'h29: is_start = 1'b1;
        8'h16: begin is_hole = 1'b1; key_hole = 4'd0; end
        8'h1E: begin is_hole = 1'b1; key_hole = 4'd1; end
        8'h26: begin is_hole = 1'b1; key_hole = 4'd2; end
        8'h25: begin is_hole = 1'b1; key_hole = 4'd3; end
        8'h2E: begin is_hole = 1'b1; key_hole = 4'd4; end
        8'h36: begin is_hole = 1'b1; key_hole = 4'd5; end
        8'h3D: begin is_hole = 1'b1; key_hole = 4'd6; end
        8'h3E: begin is_hole = 1'b1; key_hole = 4'd7; end
        8'h46: begin is_hole = 1'b1; key_hole = 4'd8; end
        default: ;
      endcase
    end
  end

  assign hole_ok = is_hole && (key_hole < NH4);

  // Per-hole hit/expiry/spawn masks and the combined life loss for this edge
  always_comb begin
    play = (state == PLAY);
    tick = play && (tick_cnt == TICK_LAST);
    for (int i = 0; i < N_HOLES; i++) begin
      key_mask[i]    = hole_ok && (key_hole == 4'(i));
      hit_mask[i]    = play && key_mask[i] && oMoles[i];
      expire_mask[i] = tick && oMoles[i] && (life[i] == 8'd1);
    end
    empty_whack = play && hole_ok && ((key_mask & oMoles) == '0);
    remain      = oMoles & ~hit_mask & ~expire_mask;
    cand        = 4'((32'(lfsr[7:0]) * N_HOLES) >> 8);
    spawn_mask  = '0;
    if (tick && (popcount(remain) < MA4)) begin
      for (int i = 0; i < N_HOLES; i++)
        spawn_mask[i] = (cand == 4'(i)) && !remain[i] && !expire_mask[i];
    end
    loss        = {1'b0, popcount(expire_mask & ~hit_mask)} +
                  {4'd0, (PENALTY != 0) && empty_whack};
    lives_after = ({1'b0, oLives} <= loss) ? 4'd0 : (oLives - loss[3:0]);
    score_inc   = (oScore == SCORE_MAX) ? oScore : (oScore + 1'b1);
  end

  // Next game phase and next visible outputs
  always_comb begin
    state_next = state;
    moles_next = oMoles;
    score_next = oScore;
    lives_next = oLives;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
    case (state)
      IDLE: begin
        if (is_start) state_next = PLAY;
      end
      PLAY: begin
        moles_next = remain | spawn_mask;
        hit_next   = |hit_mask;
        if (|hit_mask) score_next = score_inc;
        if (loss != 5'd0) begin
          miss_next  = 1'b1;
          lives_next = lives_after;
          if (lives_after == 4'd0) begin
            state_next = OVER;
            moles_next = '0;
          end
        end
      end
      OVER: begin
        if (is_start) begin
          state_next = PLAY;
          score_next = '0;
          lives_next = LIVES4;
          moles_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register game state, lifetimes, tick divider, break flag and LFSR
  always_ff @(posedge clk) begin
    if (!reset_m) begin
      state    <= IDLE;
      oMoles   <= '0;
      oScore   <= '0;
      oLives   <= LIVES4;
      oChanged <= 1'b0;
      oHit     <= 1'b0;
      oMiss    <= 1'b0;
      tick_cnt <= '0;
      brk      <= 1'b0;
      lfsr     <= 16'hACE1;
      for (int i = 0; i < N_HOLES; i++) life[i] <= 8'd0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (iKeyboard_data_en) brk <= brk ? 1'b0 : (iKeyboard_data == 8'hF0);
      state    <= state_next;
      oMoles   <= moles_next;
      oScore   <= score_next;
      oLives   <= lives_next;
      oHit     <= hit_next;
      oMiss    <= miss_next;
      oChanged <= (moles_next != oMoles) || (score_next != oScore) || (lives_next != oLives);
      if (state == PLAY && state_next == PLAY)
        tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
      else
        tick_cnt <= '0;
      for (int i = 0; i < N_HOLES; i++) begin
        if (!moles_next[i])     life[i] <= 8'd0;
        else if (spawn_mask[i]) life[i] <= UP8;
        else if (tick)          life[i] <= life[i] - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_whack_engine.sv
// tb_whack_engine: drives three differently parameterised whack_engine
// instances with the same keystroke stream and scoreboards each one against
// a behavioural game model.
module tb_whack_engine;

  typedef struct packed {
    logic [1:0] st;
    logic [8:0] moles;
    logic [7:0] score;
    logic [3:0] lives;
    logic       chg;
    logic       hit;
    logic       miss;
  } exp_t;

  localparam int TD = 4;
  localparam int UT = 3;
  localparam int LI = 3;

  int cN[3]  = '{9, 9, 5};
  int cMA[3] = '{1, 3, 2};
  int cS[3]  = '{8, 2, 4};
  int cP[3]  = '{0, 1, 1};
  logic [7:0] keymap[9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic       clk = 1'b0;
  logic       reset_m = 1'b0;
  logic [7:0] kdata = 8'h00;
  logic       ken = 1'b0;

  logic [8:0] moles0, moles1;
  logic [4:0] moles2;
  logic [7:0] score0;
  logic [1:0] score1;
  logic [3:0] score2;
  logic [3:0] lives0, lives1, lives2;
  logic [1:0] st0, st1, st2;
  logic chg0, chg1, chg2, hit0, hit1, hit2, miss0, miss1, miss2;

  int tests = 0;
  int fails = 0;

  int m_st[3], m_score[3], m_lives[3], m_cnt[3], m_lfsr[3];
  bit [8:0] m_moles[3];
  int m_life[3][9];
  bit m_brk[3], m_chg[3], m_hit[3], m_miss[3];

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  whack_engine #(.N_HOLES(9), .MAX_ACTIVE(1), .TICK_DIV(TD), .UP_TICKS(UT),
                 .SCORE_W(8), .LIVES_INIT(LI), .PENALTY(0)) dut0 (
    .clk(clk), .reset_m(reset_m), .iKeyboard_data(kdata), .iKeyboard_data_en(ken),
    .oMoles(moles0), .oChanged(chg0), .oScore(score0), .oLives(lives0),
    .oState(st0), .oHit(hit0), .oMiss(miss0));

  whack_engine #(.N_HOLES(9), .MAX_ACTIVE(3), .TICK_DIV(TD), .UP_TICKS(UT),
                 .SCORE_W(2), .LIVES_INIT(LI), .PENALTY(1)) dut1 (
    .clk(clk), .reset_m(reset_m), .iKeyboard_data(kdata), .iKeyboard_data_en(ken),
    .oMoles(moles1), .oChanged(chg1), .oScore(score1), .oLives(lives1),
    .oState(st1), .oHit(hit1), .oMiss(miss1));

  whack_engine #(.N_HOLES(5), .MAX_ACTIVE(2), .TICK_DIV(TD), .UP_TICKS(UT),
                 .SCORE_W(4), .LIVES_INIT(LI), .PENALTY(1)) dut2 (
    .clk(clk), .reset_m(reset_m), .iKeyboard_data(kdata), .iKeyboard_data_en(ken),
    .oMoles(moles2), .oChanged(chg2), .oScore(score2), .oLives(lives2),
    .oState(st2), .oHit(hit2), .oMiss(miss2));

  // Behavioural game model: one call advances game k by one clock edge
  task automatic model_step(input int k, input bit rst, input bit en, input logic [7:0] data);
    bit [8:0] old_m, expiring;
    int old_s, old_l, hole, lost, hitme, c, b;
    bit start, tick;
    if (rst) begin
      m_st[k] = 0; m_moles[k] = '0; m_score[k] = 0; m_lives[k] = LI; m_cnt[k] = 0;
      m_brk[k] = 0; m_lfsr[k] = 16'hACE1; m_chg[k] = 0; m_hit[k] = 0; m_miss[k] = 0;
      for (int i = 0; i < 9; i++) m_life[k][i] = 0;
      return;
    end
    old_m = m_moles[k]; old_s = m_score[k]; old_l = m_lives[k];
    m_hit[k] = 0; m_miss[k] = 0;
    start = 0; hole = -1;
    if (en) begin
      if (m_brk[k]) m_brk[k] = 0;
      else if (data == 8'hF0) m_brk[k] = 1;
      else if (data == 8'h29) start = 1;
      else for (int i = 0; i < 9; i++) if (data == keymap[i] && i < cN[k]) hole = i;
    end
    tick = (m_st[k] == 1) && (m_cnt[k] == TD - 1);
    if (m_st[k] == 0) begin
      if (start) m_st[k] = 1;
    end else if (m_st[k] == 2) begin
      if (start) begin
        m_st[k] = 1; m_score[k] = 0; m_lives[k] = LI; m_moles[k] = '0; m_cnt[k] = 0;
        for (int i = 0; i < 9; i++) m_life[k][i] = 0;
      end
    end else begin
      lost = 0; hitme = -1; expiring = '0;
      if (hole >= 0) begin
        if (m_moles[k][hole]) begin hitme = hole; m_hit[k] = 1; end
        else if (cP[k] != 0) lost++;
      end
      if (tick) begin
        for (int i = 0; i < cN[k]; i++) begin
          if (m_moles[k][i]) begin
            if (m_life[k][i] == 1) begin
              expiring[i] = 1;
              if (i != hitme) lost++;
            end
            m_life[k][i]--;
          end
        end
      end
      if (hitme >= 0) begin
        m_moles[k][hitme] = 0; m_life[k][hitme] = 0;
        if (m_score[k] < (1 << cS[k]) - 1) m_score[k]++;
      end
      for (int i = 0; i < 9; i++) if (expiring[i]) m_moles[k][i] = 0;
      if (tick && $countones(m_moles[k]) < cMA[k]) begin
        c = ((m_lfsr[k] & 255) * cN[k]) / 256;
        if (!m_moles[k][c] && !expiring[c]) begin m_moles[k][c] = 1; m_life[k][c] = UT; end
      end
      if (lost > 0) begin
        m_miss[k] = 1;
        m_lives[k] = (m_lives[k] > lost) ? m_lives[k] - lost : 0;
      end
      m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
      if (m_lives[k] == 0) begin
        m_st[k] = 2; m_moles[k] = '0; m_cnt[k] = 0;
        for (int i = 0; i < 9; i++) m_life[k][i] = 0;
      end
    end
    b = (m_lfsr[k] ^ (m_lfsr[k] >> 2) ^ (m_lfsr[k] >> 3) ^ (m_lfsr[k] >> 5)) & 1;
    m_lfsr[k] = (m_lfsr[k] >> 1) | (b << 15);
    m_chg[k] = (m_moles[k] != old_m) || (m_score[k] != old_s) || (m_lives[k] != old_l);
  endtask

  task automatic pushExp(input int k);
    exp_t e;
    e.st = 2'(m_st[k]); e.moles = m_moles[k]; e.score = 8'(m_score[k]);
    e.lives = 4'(m_lives[k]); e.chg = m_chg[k]; e.hit = m_hit[k]; e.miss = m_miss[k];
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t actual(input int k);
    exp_t a;
    a = '0;
    case (k)
      0: begin a.st = st0; a.moles = moles0; a.score = score0; a.lives = lives0;
               a.chg = chg0; a.hit = hit0; a.miss = miss0; end
      1: begin a.st = st1; a.moles = moles1; a.score = {6'd0, score1}; a.lives = lives1;
               a.chg = chg1; a.hit = hit1; a.miss = miss1; end
      default: begin a.st = st2; a.moles = {4'd0, moles2}; a.score = {4'd0, score2};
               a.lives = lives2; a.chg = chg2; a.hit = hit2; a.miss = miss2; end
    endcase
    return a;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: cycle bound expired, got no event, expected one", name);
  endtask

  // Monitor: pop one expectation per instance and compare every output
  task automatic checkOutput();
    exp_t e, a;
    bit have;
    for (int k = 0; k < 3; k++) begin
      have = 0;
      e = '0;
      case (k)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
      endcase
      if (have) begin
        a = actual(k);
        cmp($sformatf("d%0d.oState", k), 32'(a.st), 32'(e.st));
        cmp($sformatf("d%0d.oMoles", k), 32'(a.moles), 32'(e.moles));
        cmp($sformatf("d%0d.oScore", k), 32'(a.score), 32'(e.score));
        cmp($sformatf("d%0d.oLives", k), 32'(a.lives), 32'(e.lives));
        cmp($sformatf("d%0d.oChanged", k), 32'(a.chg), 32'(e.chg));
        cmp($sformatf("d%0d.oHit", k), 32'(a.hit), 32'(e.hit));
        cmp($sformatf("d%0d.oMiss", k), 32'(a.miss), 32'(e.miss));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    checkOutput();
  end

  // One clock of stimulus; the model advances on the same edge as the DUTs
  task automatic applyStimulus(input bit rst, input bit en, input logic [7:0] data);
    reset_m = !rst; ken = en; kdata = data;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      model_step(k, rst, en, data);
      pushExp(k);
    end
    #1;
    ken = 1'b0; kdata = 8'h00;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendKey(input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, data);
  endtask

  task automatic sendStart();
    if (m_brk[0]) sendKey(8'h00);
    sendKey(8'h29);
  endtask

  function automatic int firstUp(input int k);
    for (int i = 0; i < 9; i++) if (m_moles[k][i]) return i;
    return -1;
  endfunction

  function automatic int firstEmpty(input int k);
    for (int i = 0; i < cN[k]; i++) if (!m_moles[k][i]) return i;
    return -1;
  endfunction

  // Stimulus: directed game scenarios followed by randomised play
  initial begin
    bit found;
    int h, r, picks[$];
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (2) idle();
    sendKey(8'h16);
    sendKey(8'h55);
    sendKey(8'h00);
    sendStart();

    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (m_moles[0] != '0) found = 1; else idle();
    end
    if (!found) timeoutFail("first_spawn");
    h = firstUp(0);
    if (h >= 0) sendKey(keymap[h]);
    idle();
    if (h >= 0) begin sendKey(8'hF0); sendKey(keymap[h]); end
    idle();

    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (m_st[0] == 2) found = 1; else idle();
    end
    if (!found) timeoutFail("game_over");
    idle();
    sendStart();

    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (m_st[1] == 1 && firstEmpty(1) >= 0) begin
        sendKey(keymap[firstEmpty(1)]); found = 1;
      end else if (m_st[1] == 2) sendStart();
      else idle();
    end
    if (!found) timeoutFail("penalty_whack");

    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      h = -1;
      if (m_st[0] == 1 && m_cnt[0] == TD - 1)
        for (int i = 0; i < 9; i++) if (m_moles[0][i] && m_life[0][i] == 1) h = i;
      if (h >= 0) begin sendKey(keymap[h]); found = 1; end
      else if (m_st[0] != 1) sendStart();
      else idle();
    end
    if (!found) timeoutFail("hit_on_expiry");

    for (int n = 0; n < 900; n++) begin
      r = $urandom_range(0, 99);
      picks.delete();
      for (int i = 0; i < 9; i++) if (m_moles[1][i]) picks.push_back(i);
      if ((m_st[0] == 2 || m_st[1] == 2 || m_st[2] == 2) && r < 30) sendStart();
      else if (r < 40) idle();
      else if (r < 72 && picks.size() > 0) sendKey(keymap[picks[$urandom_range(0, picks.size() - 1)]]);
      else if (r < 82) sendKey(keymap[$urandom_range(0, 8)]);
      else if (r < 87) sendKey(8'hF0);
      else if (r < 91) sendKey(8'h29);
      else sendKey(8'($urandom_range(0, 255)));
    end

    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_st[0] == 1 && m_moles[0] != '0) found = 1;
      else if (m_st[0] != 1) sendStart();
      else idle();
    end
    if (!found) timeoutFail("midgame_moles");
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) idle();

    @(negedge clk);
    #1;
    if (q0.size() + q1.size() + q2.size() != 0) timeoutFail("scoreboard_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
